mlp_layer_engine: RTL and testbench
===================================

# mlp_layer_engine

Parametrised fully connected neural layer for the MLP datapath. It receives a byte stream containing an input count, a weight set for `N_NEURONS` neurons and then input vectors, and multiply-accumulates all neurons in parallel. It applies a selectable activation and streams one 8-bit result per neuron downstream. Weights stay resident, so successive vectors reuse them without reloading. It sits between the UART receive path and the next layer or UART transmit path.

## Interface
- `N_NEURONS`, 4: neurons computed in parallel (≥1).
- `MAX_INPUTS`, 16: maximum input vector length K.
- `DATA_W`, 8: signed weight, input and result width.
- `ACC_W`, 20: signed accumulator width; must satisfy ≥ 2·DATA_W + clog2(MAX_INPUTS).
- `SHIFT`, 0: arithmetic right shift applied to the accumulator before activation.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-low; clock clk.
- `in_data`  in  DATA_W  stream byte (count, weights, inputs).
- `in_valid`  in  1  in_data valid.
- `in_ready`  out  1  engine accepts the byte this cycle.
- `act_mode`  in  2  00 linear-sat, 01 ReLU-sat, 10 hard-tanh, 11 same as 00.
- `reload`  in  1  request a new count and weight load.
- `out_data`  out  DATA_W  activated neuron result, signed.
- `out_idx`  out  clog2(N_NEURONS) (min 1)  neuron index of out_data.
- `out_valid`  out  1  result valid.
- `out_last`  out  1  high with the result of neuron N_NEURONS-1.
- `out_ready`  in  1  downstream accepts the result.
- `err_len`  out  1  one-cycle pulse when the count byte is illegal.

## Operation
- Handshake: a transfer occurs on a cycle where valid && ready.
- S_CNT:
  - in_ready=1.
  - On transfer, K = in_data taken as unsigned.
  - K = 0 or K > MAX_INPUTS: pulse err_len, stay in S_CNT.
  - Otherwise store K and go to S_W.
- S_W:
  - in_ready=1.
  - Accepts K·N_NEURONS weights in neuron-major order: w[0][0..K-1], then w[1][0..K-1], and so on.
  - After the last weight, clear all accumulators, clear the input counter, and go to S_X.
- S_X:
  - in_ready=1 except on the reload-override cycle.
  - On each transfer of x[j], every neuron n adds sign-extended w[n][j]·x[j] (16-bit signed product) to acc[n] in the same cycle.
  - After x[K-1], go to S_ACT.
- S_ACT:
  - in_ready=0, one cycle.
  - For each n, compute v = acc[n] >>> SHIFT.
  - Linear: saturate v to [-128, 127].
  - ReLU: negative → 0, else saturate to 127.
  - Hard-tanh: clamp v to [-64, 64] (±1.0 in Q1.6).
  - Results are registered; act_mode is sampled in this cycle only.
- S_OUT:
  - in_ready=0.
  - Present results for idx 0..N_NEURONS-1 in order.
  - out_data and out_idx are held stable until out_ready.
  - After the transfer with out_last=1: clear accumulators and the input counter, go to S_X.
- Reload:
  - Honoured only in S_X when zero inputs of the current vector have been accepted.
  - When honoured, in_ready=0 that cycle, the byte is not consumed, and the next state is S_CNT.
  - Ignored in all other states and once a vector is in progress.
- Reset (any state, including mid-vector or mid-output):
  - Next state S_CNT.
  - Accumulators, counters and K cleared.
  - Weight contents are don't-care.
  - No partial output completes.

## Timing
- Reset values: in_ready=0 during the reset cycle, then 1 in S_CNT. out_valid=0, out_last=0, out_data=0, out_idx=0, err_len=0.
- Latency: last x transfer at cycle t → S_ACT at t+1 → out_valid=1 with idx 0 at t+2.
- Throughput:
  - With out_ready held high, one result per cycle; the vector occupies N_NEURONS cycles in S_OUT.
  - in_ready returns to 1 in the cycle after the final output transfer.
- Input side: one byte per cycle at full rate; in_valid gaps stall without state change.
- out_valid, once asserted, never drops before its transfer.
- err_len is asserted the cycle after the offending count transfer, for exactly one cycle.

## Test plan
- Setup for the next three scenarios: N=4, SHIFT=0, K=2. Weights n0 = 1,2; n1 = -1,-1; n2 = 127,127; n3 = 0,0. Input x = 10,20.
- Linear (act_mode=00), out_ready=1 → 50, -30 (0xE2), 127 (saturated from 3810), 0. idx 0..3; out_last only on idx 3; first out_valid 2 cycles after x=20.
- Same setup, ReLU (act_mode=01) → 50, 0, 127, 0. Hard-tanh (act_mode=10) → 50, -30, 64, 0.
- Second vector x = 1,1 without reload → 3, -2, 127, 0. Weights are reused; out_ready toggled randomly; data held stable while stalled.
- Count byte 0, then count byte 17 → err_len pulses twice, state stays in S_CNT. Then count 1, weights 2,3,4,5, x=-3 → -6, -9, -12, -15.
- Reload asserted with in_valid in S_X before any x → byte not consumed, next byte is taken as the count. Reload asserted after one x → ignored.
- Reset asserted on the second output cycle → out_valid=0 next cycle and in_ready=1 in S_CNT. A full reload then produces correct results.

Source files
------------

// File: rtl/mlp_layer_engine.sv
// ---------------------------------------------------------------------------
// mlp_layer_engine
//
// Fully connected neural layer. A byte stream delivers an input count K, then
// K*N_NEURONS signed weights (neuron-major), then any number of K-element
// input vectors. All neurons multiply-accumulate in parallel as each input
// byte arrives. After the last element the accumulators are shifted,
// activated (linear-sat / ReLU-sat / hard-tanh) and streamed out one neuron
// per transfer. Weights stay resident until a reload is requested between
// vectors.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-low reset
//   in_data    stream byte (count, weights, inputs)
//   in_valid   in_data valid
//   in_ready   engine accepts the byte this cycle
//   act_mode   00 linear-sat, 01 ReLU-sat, 10 hard-tanh, 11 linear-sat
//   reload     request a new count and weight load (between vectors only)
//   out_data   activated neuron result, signed
//   out_idx    neuron index of out_data
//   out_valid  result valid
//   out_last   high with the result of neuron N_NEURONS-1
//   out_ready  downstream accepts the result
//   err_len    one-cycle pulse when the count byte is 0 or > MAX_INPUTS
// ---------------------------------------------------------------------------
module mlp_layer_engine #(
  parameter int N_NEURONS  = 4,
  parameter int MAX_INPUTS = 16,
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 20,
  parameter int SHIFT      = 0,
  localparam int IDX_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        act_mode,
  input  logic              reload,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              err_len
);

  // Counter width holds K itself (1..MAX_INPUTS); J_W addresses a weight slot.
  localparam int CNT_W  = $clog2(MAX_INPUTS + 1);
  localparam int J_W    = (MAX_INPUTS > 1) ? $clog2(MAX_INPUTS) : 1;
  localparam int DEPTH  = 1 << J_W;
  localparam int PROD_W = 2 * DATA_W;

  // Saturation bounds expressed in accumulator width so comparisons stay signed.
  localparam logic signed [ACC_W-1:0] SAT_HI  = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO  = ACC_W'(-(1 << (DATA_W - 1)));
  // Hard-tanh clamps to +/-1.0 in a Q1.(DATA_W-2) reading of the result.
  localparam logic signed [ACC_W-1:0] TANH_HI = ACC_W'(1 << (DATA_W - 2));
  localparam logic signed [ACC_W-1:0] TANH_LO = ACC_W'(-(1 << (DATA_W - 2)));
  localparam logic signed [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};

  typedef enum logic [2:0] {
    S_CNT = 3'd0,
    S_W   = 3'd1,
    S_X   = 3'd2,
    S_ACT = 3'd3,
    S_OUT = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0]               k;
  logic [CNT_W-1:0]               k_last;
  logic [IDX_W-1:0]               w_n;
  logic [CNT_W-1:0]               w_j;
  logic [CNT_W-1:0]               x_j;
  logic [DATA_W-1:0]              w_mem [N_NEURONS][DEPTH];
  logic signed [ACC_W-1:0]        acc   [N_NEURONS];
  logic [DATA_W-1:0]              res   [N_NEURONS];
  logic [IDX_W-1:0]               idx_next;

  logic in_fire;
  logic out_fire;
  logic cnt_bad;
  logic w_last;
  logic x_last;
  logic idx_last;
  logic reload_take;

  // Signed w*x product, sign-extended into the accumulator width.
  function automatic logic signed [ACC_W-1:0] mac_term(
    input logic [DATA_W-1:0] w,
    input logic [DATA_W-1:0] x
  );
    logic signed [PROD_W-1:0] p;
    p = $signed(w) * $signed(x);
    return ACC_W'(p);
  endfunction

  // Shift then clamp an accumulator into the DATA_W result range for a mode.
  function automatic logic [DATA_W-1:0] activate(
    input logic signed [ACC_W-1:0] a,
    input logic [1:0]              mode
  );
    logic signed [ACC_W-1:0] v;
    logic signed [ACC_W-1:0] lo;
    logic signed [ACC_W-1:0] hi;
    logic [DATA_W-1:0]       r;
    v = a >>> SHIFT;
    case (mode)
      2'b01: begin
        lo = ACC_ZERO;
        hi = SAT_HI;
      end
      2'b10: begin
        lo = TANH_LO;
        hi = TANH_HI;
      end
      default: begin
        lo = SAT_LO;
        hi = SAT_HI;
      end
    endcase
    if (v > hi) begin
      r = hi[DATA_W-1:0];
    end else if (v < lo) begin
      r = lo[DATA_W-1:0];
    end else begin
      r = v[DATA_W-1:0];
    end
    return r;
  endfunction

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign k_last   = k - CNT_W'(1);
  assign cnt_bad  = (in_data == {DATA_W{1'b0}}) || (32'(in_data) > 32'(MAX_INPUTS));
  assign w_last   = (w_n == IDX_W'(N_NEURONS - 1)) && (w_j == k_last);
  assign x_last   = (x_j == k_last);
  assign idx_last = (out_idx == IDX_W'(N_NEURONS - 1));
  assign idx_next = out_idx + IDX_W'(1);
  // A reload only lands between vectors: in S_X before any element is taken.
  assign reload_take = (state == S_X) && reload && (x_j == {CNT_W{1'b0}});

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_CNT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      S_CNT: begin
        if (in_fire && !cnt_bad) begin
          state_next = S_W;
        end else begin
          state_next = S_CNT;
        end
      end
      S_W: begin
        if (in_fire && w_last) begin
          state_next = S_X;
        end else begin
          state_next = S_W;
        end
      end
      S_X: begin
        if (reload_take) begin
          state_next = S_CNT;
        end else if (in_fire && x_last) begin
          state_next = S_ACT;
        end else begin
          state_next = S_X;
        end
      end
      S_ACT: begin
        state_next = S_OUT;
      end
      S_OUT: begin
        if (out_fire && idx_last) begin
          state_next = S_X;
        end else begin
          state_next = S_OUT;
        end
      end
      default: begin
        state_next = S_CNT;
      end
    endcase
  end

  // Input-side ready: held low in reset and on the cycle a reload is honoured.
  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      in_ready = 1'b0;
    end else begin
      case (state)
        S_CNT:   in_ready = 1'b1;
        S_W:     in_ready = 1'b1;
        S_X:     in_ready = !(reload && (x_j == {CNT_W{1'b0}}));
        default: in_ready = 1'b0;
      endcase
    end
  end

  // Weight storage; contents are not reset, only overwritten by a load.
  always_ff @(posedge clk) begin
    if (reset && (state == S_W) && in_fire) begin
      w_mem[w_n][w_j[J_W-1:0]] <= in_data;
    end else begin
      w_mem <= w_mem;
    end
  end

  // Counters, accumulators, activation results and the output register stage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      k         <= {CNT_W{1'b0}};
      w_n       <= {IDX_W{1'b0}};
      w_j       <= {CNT_W{1'b0}};
      x_j       <= {CNT_W{1'b0}};
      err_len   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= {DATA_W{1'b0}};
      out_idx   <= {IDX_W{1'b0}};
      for (int n = 0; n < N_NEURONS; n++) begin
        acc[n] <= ACC_ZERO;
        res[n] <= {DATA_W{1'b0}};
      end
    end else begin
      err_len <= 1'b0;
      case (state)
        S_CNT: begin
          if (in_fire) begin
            if (cnt_bad) begin
              err_len <= 1'b1;
            end else begin
              k   <= CNT_W'(in_data);
              w_n <= {IDX_W{1'b0}};
              w_j <= {CNT_W{1'b0}};
            end
          end
        end
        S_W: begin
          if (in_fire) begin
            // Walk w[n][0..K-1] then move to the next neuron.
            if (w_j == k_last) begin
              w_j <= {CNT_W{1'b0}};
              w_n <= w_n + IDX_W'(1);
            end else begin
              w_j <= w_j + CNT_W'(1);
            end
            if (w_last) begin
              x_j <= {CNT_W{1'b0}};
              for (int n = 0; n < N_NEURONS; n++) begin
                acc[n] <= ACC_ZERO;
              end
            end
          end
        end
        S_X: begin
          if (in_fire) begin
            for (int n = 0; n < N_NEURONS; n++) begin
              acc[n] <= acc[n] + mac_term(w_mem[n][x_j[J_W-1:0]], in_data);
            end
            x_j <= x_j + CNT_W'(1);
          end
        end
        S_ACT: begin
          // act_mode is only looked at here; neuron 0 goes straight to the port.
          for (int n = 0; n < N_NEURONS; n++) begin
            res[n] <= activate(acc[n], act_mode);
          end
          out_data  <= activate(acc[0], act_mode);
          out_idx   <= {IDX_W{1'b0}};
          out_valid <= 1'b1;
          out_last  <= (N_NEURONS == 1);
        end
        S_OUT: begin
          if (out_fire) begin
            if (idx_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              x_j       <= {CNT_W{1'b0}};
              for (int n = 0; n < N_NEURONS; n++) begin
                acc[n] <= ACC_ZERO;
              end
            end else begin
              out_idx  <= idx_next;
              out_data <= res[idx_next];
              out_last <= (idx_next == IDX_W'(N_NEURONS - 1));
            end
          end
        end
        default: begin
          err_len <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_layer_engine.sv
// ---------------------------------------------------------------------------
// tb_mlp_layer_engine
//
// Scoreboard bench: stimulus tasks push the expected results of each vector
// (computed from plain integer sums and clamps) into a queue; an independent
// monitor pops and compares on every output transfer and checks that a
// stalled output holds steady.
// ---------------------------------------------------------------------------
module tb_mlp_layer_engine;

  localparam int N     = 4;
  localparam int MAXK  = 16;
  localparam int SHIFT = 0;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] act_mode;
  logic       reload;
  logic [7:0] out_data;
  logic [1:0] out_idx;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;
  logic       err_len;

  typedef struct {
    int data;
    int idx;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cur_k;
  int   cur_w[N][MAXK];
  int   cur_x[MAXK];
  bit   gap_en     = 1'b0;
  bit   rand_ready = 1'b0;

  always #5 clk = ~clk;

  mlp_layer_engine #(
    .N_NEURONS (N),
    .MAX_INPUTS(MAXK),
    .DATA_W    (8),
    .ACC_W     (20),
    .SHIFT     (SHIFT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .act_mode (act_mode),
    .reload   (reload),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_ready(out_ready),
    .err_len  (err_len)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference activation: shift, then clamp by mode.
  function automatic int act_ref(input int s, input logic [1:0] m);
    int v;
    v = s >>> SHIFT;
    if (m == 2'b01) begin
      if (v < 0) return 0;
      if (v > 127) return 127;
      return v;
    end
    if (m == 2'b10) begin
      if (v < -64) return -64;
      if (v > 64) return 64;
      return v;
    end
    if (v < -128) return -128;
    if (v > 127) return 127;
    return v;
  endfunction

  // Downstream ready: always high or random per cycle.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compares every output transfer against the scoreboard.
  initial begin
    bit chk_stable;
    int p_data;
    int p_idx;
    chk_stable = 1'b0;
    p_data = 0;
    p_idx = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (chk_stable) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", $signed(out_data), p_data);
          check("hold_idx", out_idx, p_idx);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: got idx %0d data %0d, expected none", out_idx, $signed(out_data));
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_data", $signed(out_data), e.data);
            check("out_idx", out_idx, e.idx);
            check("out_last", out_last, e.last);
          end
        end
        chk_stable = out_valid && !out_ready;
        p_data = $signed(out_data);
        p_idx = out_idx;
      end else begin
        chk_stable = 1'b0;
      end
    end
  end

  // Offer one byte; returns one cycle after it was accepted.
  task automatic send(input int b);
    int t;
    in_data = 8'(b);
    in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready got 0, expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (gap_en && $urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  // Count byte followed by weights in neuron-major order.
  task automatic load(input int k);
    send(k);
    reload = 1'b0;
    for (int n = 0; n < N; n++) begin
      for (int j = 0; j < k; j++) begin
        send(cur_w[n][j]);
      end
    end
  endtask

  task automatic push_exp(input logic [1:0] mode);
    act_mode = mode;
    for (int n = 0; n < N; n++) begin
      int s;
      s = 0;
      for (int j = 0; j < cur_k; j++) begin
        s += cur_w[n][j] * cur_x[j];
      end
      exp_q.push_back('{act_ref(s, mode), n, (n == N - 1)});
    end
  endtask

  // Wait (bounded) until every expected result has been seen.
  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d results pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input logic [1:0] mode, input bit chk_lat);
    push_exp(mode);
    for (int j = 0; j < cur_k; j++) begin
      send(cur_x[j]);
    end
    if (chk_lat) begin
      @(negedge clk);
      check("lat_t1_valid", out_valid, 0);
      @(negedge clk);
      check("lat_t2_valid", out_valid, 1);
      check("lat_t2_idx", out_idx, 0);
    end
    drain();
  endtask

  task automatic rand_weights(input int k);
    cur_k = k;
    for (int n = 0; n < N; n++) begin
      for (int j = 0; j < MAXK; j++) begin
        cur_w[n][j] = int'($urandom_range(0, 255)) - 128;
      end
    end
  endtask

  task automatic rand_x();
    for (int j = 0; j < MAXK; j++) begin
      cur_x[j] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    act_mode = 2'b00;
    reload   = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_err_len", err_len, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("cnt_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Directed weight set, K=2
    cur_k = 2;
    cur_w[0][0] = 1;   cur_w[0][1] = 2;
    cur_w[1][0] = -1;  cur_w[1][1] = -1;
    cur_w[2][0] = 127; cur_w[2][1] = 127;
    cur_w[3][0] = 0;   cur_w[3][1] = 0;
    load(2);
    cur_x[0] = 10;
    cur_x[1] = 20;
    run_vec(2'b00, 1'b1);
    run_vec(2'b01, 1'b0);
    run_vec(2'b10, 1'b0);

    // Second vector reuses weights, downstream stalls at random
    rand_ready = 1'b1;
    cur_x[0] = 1;
    cur_x[1] = 1;
    run_vec(2'b00, 1'b0);

    // Reload with a byte pending: byte must not be consumed, then is the count
    reload   = 1'b1;
    in_data  = 8'd0;
    in_valid = 1'b1;
    @(negedge clk);
    check("reload_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    reload = 1'b0;
    send(0);
    @(negedge clk);
    check("err_len_k0", err_len, 1);
    @(negedge clk);
    check("err_len_k0_drop", err_len, 0);
    @(posedge clk);
    #1;
    send(17);
    @(negedge clk);
    check("err_len_k17", err_len, 1);
    @(negedge clk);
    check("err_len_k17_drop", err_len, 0);
    check("err_stay_cnt", in_ready, 1);
    @(posedge clk);
    #1;
    cur_k = 1;
    cur_w[0][0] = 2;
    cur_w[1][0] = 3;
    cur_w[2][0] = 4;
    cur_w[3][0] = 5;
    load(1);
    cur_x[0] = -3;
    run_vec(2'b00, 1'b0);

    // Reload raised after one element must be ignored
    rand_weights(3);
    rand_x();
    reload = 1'b1;
    load(3);
    push_exp(2'b00);
    send(cur_x[0]);
    reload = 1'b1;
    @(negedge clk);
    check("reload_ignored", in_ready, 1);
    @(posedge clk);
    #1;
    send(cur_x[1]);
    send(cur_x[2]);
    reload = 1'b0;
    drain();

    // Reset on the second output cycle
    rand_ready = 1'b0;
    rand_weights(2);
    rand_x();
    reload = 1'b1;
    load(2);
    push_exp(2'b00);
    send(cur_x[0]);
    send(cur_x[1]);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_cnt_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rand_weights(5);
    rand_x();
    load(5);
    run_vec(2'b01, 1'b0);

    // Randomised vectors with occasional reloads, gaps and stalls
    gap_en = 1'b1;
    rand_ready = 1'b1;
    for (int it = 0; it < 25; it++) begin
      if (it == 0 || $urandom_range(0, 2) == 0) begin
        rand_weights(int'($urandom_range(1, MAXK)));
        reload = 1'b1;
        load(cur_k);
      end
      rand_x();
      run_vec(2'($urandom_range(0, 3)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
